// File: rtl/add_arb_pkg.sv
// Shared types and sizing helpers for the add/sub sharing arbiter.
package add_arb_pkg;

   localparam int ADD_ARB_NREQ_DEF = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
   } add_op_t;

   // ID width; never let it collapse to zero bits
   function automatic int idw_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adder32bit.sv
// 32-bit ripple adder built from eight 4-bit full-adder slices.
// Exposes the carry into bit 31 so the user can derive signed overflow.
module fa4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       c3
);
   logic [4:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[4];
   assign c3   = c[3];
endmodule

module Adder32bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout,
   output logic        c31
);
   logic [8:0] c;
   logic [7:0] c3;

   assign c[0] = cin;

   for (genvar g = 0; g < 8; g++) begin : g_slice
      fa4_slice u_fa4 (
         .a    (a[4*g +: 4]),
         .b    (b[4*g +: 4]),
         .cin  (c[g]),
         .s    (s[4*g +: 4]),
         .cout (c[g+1]),
         .c3   (c3[g])
      );
   end

   assign cout = c[8];
   assign c31  = c3[7];
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request searching from ptr+1.
import add_arb_pkg::*;

module rr_arbiter #(
   parameter int NREQ = ADD_ARB_NREQ_DEF,
   parameter int IDW  = idw_of(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);
   logic found;
   int   idx;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = IDW'(idx);
         end
      end
   end
endmodule

// File: rtl/add_share_arb.sv
// Round-robin sharing of one 32-bit adder among NREQ requesters, 1-entry buffer.
// Optional perf counters under ADD_SHARE_ARB_PERF_EN.
module add_share_arb
   import add_arb_pkg::*;
#(
   parameter int NREQ = ADD_ARB_NREQ_DEF,
   parameter int IDW  = idw_of(NREQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [NREQ*32-1:0] req_a,
   input  logic [NREQ*32-1:0] req_b,
   input  logic [NREQ-1:0]  req_sub,
`ifdef ADD_SHARE_ARB_PERF_EN
   output logic [31:0]      perf_ops,
   output logic [31:0]      perf_stall,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [IDW-1:0]   rsp_id,
   output logic [31:0]      rsp_y,
   output logic             rsp_cout,
   output logic             rsp_ovf,
   output logic             rsp_zero
);
   add_op_t        buf_q, win_op;
   logic [IDW-1:0] id_q, ptr_q, gnt_id;
   logic           full_q, en, accept, consume, c31;

   assign rsp_valid = full_q & ~reset;
   assign consume   = rsp_valid & rsp_ready;
   // Grant into an empty buffer, or refill while the current result drains
   assign en        = ~reset & (~full_q | rsp_ready);
   assign accept    = |req_ready;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req    (req_valid),
      .ptr    (ptr_q),
      .en     (en),
      .gnt    (req_ready),
      .gnt_id (gnt_id)
   );

   always_comb begin
      win_op.a   = req_a[32*int'(gnt_id) +: 32];
      win_op.b   = req_b[32*int'(gnt_id) +: 32];
      win_op.sub = req_sub[gnt_id];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q <= 1'b0;
         ptr_q  <= IDW'(NREQ - 1);
      end else if (accept) begin
         full_q <= 1'b1;
         ptr_q  <= gnt_id;
      end else if (consume) begin
         full_q <= 1'b0;
      end
   end

   // Payload needs no reset; it is only observed while full_q is set
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q <= win_op;
         id_q  <= gnt_id;
      end
   end

   Adder32bit u_add (
      .a    (buf_q.a),
      .b    (buf_q.b ^ {32{buf_q.sub}}),
      .cin  (buf_q.sub),
      .s    (rsp_y),
      .cout (rsp_cout),
      .c31  (c31)
   );

   assign rsp_id   = id_q;
   assign rsp_ovf  = rsp_cout ^ c31;
   assign rsp_zero = (rsp_y == 32'd0);

`ifdef ADD_SHARE_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_ops   <= '0;
         perf_stall <= '0;
      end else begin
         perf_ops   <= perf_ops + 32'(accept);
         perf_stall <= perf_stall + 32'(rsp_valid & ~rsp_ready);
      end
   end
`endif
endmodule

// File: tb/tb_add_share_arb.sv
// Directed bench for add_share_arb; inputs driven and outputs checked on negedge.
module tb_add_share_arb;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid, req_ready, req_sub;
   logic [NREQ*32-1:0]  req_a, req_b;
   logic                rsp_valid, rsp_ready, rsp_cout, rsp_ovf, rsp_zero;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         rsp_y;
`ifdef ADD_SHARE_ARB_PERF_EN
   logic [31:0]         perf_ops, perf_stall;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   add_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
`ifdef ADD_SHARE_ARB_PERF_EN
      .perf_ops   (perf_ops),
      .perf_stall (perf_stall),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_y      (rsp_y),
      .rsp_cout   (rsp_cout),
      .rsp_ovf    (rsp_ovf),
      .rsp_zero   (rsp_zero)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_sub[i]        = sub;
      req_valid[i]      = 1'b1;
   endtask

   // Present one op, check the grant, then check the response a cycle later
   task automatic one_op(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] y, input logic cout, input logic ovf);
      set_req(i, a, b, sub);
      #1 chk({tag, ".rdy"}, 64'(req_ready), 64'(1 << i));
      @(negedge clk);
      req_valid = '0;
      chk({tag, ".vld"},  64'(rsp_valid), 64'd1);
      chk({tag, ".id"},   64'(rsp_id),    64'(i));
      chk({tag, ".y"},    64'(rsp_y),     64'(y));
      chk({tag, ".cout"}, 64'(rsp_cout),  64'(cout));
      chk({tag, ".ovf"},  64'(rsp_ovf),   64'(ovf));
      chk({tag, ".zero"}, 64'(rsp_zero),  64'(y == 32'd0));
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_sub   = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      // Accept attempt during reset must be ignored
      set_req(0, 32'd9, 32'd9, 1'b0);
      #1 chk("rst.rdy", 64'(req_ready), 64'd0);
      chk("rst.vld", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      req_valid = '0;
      reset     = 1'b0;
      #1 chk("rst.empty", 64'(rsp_valid), 64'd0);
      @(negedge clk);

      one_op("add5p3",  0, 32'd5,        32'd3, 1'b0, 32'd8,        1'b0, 1'b0);
      one_op("subMin",  2, 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
      one_op("addMax",  1, 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1);
      one_op("sub0m1",  3, 32'd0,        32'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      one_op("subZero", 0, 32'd5,        32'd5, 1'b1, 32'd0,        1'b1, 1'b0);
      one_op("addWrap", 1, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd1,        1'b1, 1'b0);

      // All requesters busy: strict rotation from requester 0 after reset
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 * i, 32'(i), 1'b0);
      for (int k = 0; k < 8; k++) begin
         #1 chk("rr.rdy", 64'(req_ready), 64'(1 << (k % 4)));
         @(negedge clk);
         chk("rr.vld", 64'(rsp_valid), 64'd1);
         chk("rr.id",  64'(rsp_id),    64'(k % 4));
         chk("rr.y",   64'(rsp_y),     64'(32'h101 * (k % 4)));
      end

      // Backpressure with requests still pending: response held, no grants
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp.rdy", 64'(req_ready), 64'd0);
         @(negedge clk);
         chk("bp.vld", 64'(rsp_valid), 64'd1);
         chk("bp.id",  64'(rsp_id),    64'd3);
         chk("bp.y",   64'(rsp_y),     64'h303);
      end
      rsp_ready = 1'b1;
      #1 chk("bp.refill", 64'(req_ready), 64'd1);
      @(negedge clk);
      chk("bp.nid", 64'(rsp_id),    64'd0);
      chk("bp.nvl", 64'(rsp_valid), 64'd1);
      req_valid = '0;
      @(negedge clk);

      // Reset while full drops the buffered op
      rsp_ready = 1'b0;
      set_req(1, 32'd7, 32'd7, 1'b0);
      @(negedge clk);
      req_valid = '0;
      chk("mid.full", 64'(rsp_valid), 64'd1);
      reset = 1'b1;
      #1 chk("mid.rstvld", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      reset     = 1'b0;
      rsp_ready = 1'b1;
      #1 chk("mid.drop", 64'(rsp_valid), 64'd0);
      for (int i = 0; i < NREQ; i++) set_req(i, 32'd1, 32'(i), 1'b0);
      #1 chk("mid.first", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = '0;
      chk("mid.id", 64'(rsp_id), 64'd0);
      chk("mid.y",  64'(rsp_y),  64'd1);
      @(negedge clk);

`ifdef ADD_SHARE_ARB_PERF_EN
      do_reset();
      #1 chk("perf.clr", 64'(perf_ops), 64'd0);
      set_req(0, 32'd1, 32'd1, 1'b0);
      repeat (6) @(negedge clk);
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rsp_ready = 1'b1;
      chk("perf.ops",   64'(perf_ops),   64'd6);
      chk("perf.stall", 64'(perf_stall), 64'd2);
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
